mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one pipelined W x W multiplier (fixed latency LAT, no enable/stall) between two requesters.
//  Requester 0 is the manual key path; requester 1 is the auto-increment path.
//  The block arbitrates round-robin, issues operands to the multiplier and tracks in-flight ops with a tag pipe.
//  It returns each product to its owner with a valid pulse and id. Sits between the main FSM and the multiplier, on clk_300hz.
// PARAMETERS
//  W     8  operand width; product width is 2*W
//  LAT   4  multiplier latency: clock edges from operands on mul_a/mul_b to the matching product on mul_p (LAT>=1)
// PORTS
//  clk        in   1    clock, rising edge
//  rst_       in   1    asynchronous reset, active low
//  clr        in   1    synchronous flush of all in-flight operations
//  req0       in   1    requester 0 request (level); a0/b0 held stable while high
//  a0, b0     in   W    requester 0 operands
//  gnt0       out  1    one-cycle pulse: a0/b0 were captured on the previous edge
//  req1       in   1    requester 1 request (level)
//  a1, b1     in   W    requester 1 operands
//  gnt1       out  1    one-cycle pulse: a1/b1 were captured on the previous edge
//  mul_a      out  W    registered operand A to multiplier
//  mul_b      out  W    registered operand B to multiplier
//  mul_p      in   2W   multiplier product
//  rsp_valid  out  1    one-cycle pulse: rsp_data/rsp_id valid
//  rsp_id     out  1    owner of rsp_data (0/1)
//  rsp_data   out  2W   registered product
//  busy       out  1    1 while any tag-pipe entry is valid
// BEHAVIOUR
//  Reset (rst_=0, async): gnt0=gnt1=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
//   Also: tag pipe cleared, rr pointer=1, so req0 wins the first tie.
//  Eligibility: reqN is eligible only when reqN=1 and gntN=0. No requester is granted twice back-to-back;
//   each requester sees at most one issue per 2 cycles.
//  Arbitration:
//   - Exactly one eligible -> grant it.
//   - Both eligible -> grant the one other than rr pointer; rr pointer <= granted id.
//   - Under continuous dual request the grants alternate 0,1,0,1 with one issue every cycle.
//  Issue at edge k: mul_a/mul_b <= winner operands; gnt<winner> = 1 during cycle k+1. The requester must drop req or
//   change operands in that cycle; operands present during the gnt cycle are not sampled.
//  No issue: gnt0=gnt1=0; mul_a/mul_b hold their last values; tag entry inserted with valid=0.
//  Tag pipe: LAT stages of {valid,id} shifted every edge, entry inserted together with mul_a/mul_b.
//  Completion: at the edge where the stage-LAT entry is valid:
//   rsp_data <= mul_p; rsp_id <= entry id; rsp_valid = 1 for one cycle.
//   Latency is gnt pulse -> rsp_valid = LAT cycles (issue edge -> rsp_valid edge = LAT+1).
//  rsp_data/rsp_id hold their last value when rsp_valid=0. Product is the unsigned 2W-bit result; no truncation.
//  busy = OR of tag-pipe valid bits, registered.
//  clr=1 at an edge:
//   - All tag valid bits, gnt0/gnt1 and rsp_valid go to 0; rr pointer=1; no grant that edge.
//   - mul_a/mul_b are held.
//   - clr beats a simultaneous req; in-flight products are discarded and never reported.
//  Async reset mid-operation: in-flight ops are dropped identically to clr.
//  Requester dropping req before its grant: no issue, no penalty. Full back-to-back throughput is 1 op/cycle.
// CONFIGURATION
//  MUL_ARB_STATS_EN defined:
//   - Adds outputs cnt0, cnt1 [15:0]: per-requester grant counters, +1 on each gntN pulse, saturating at 16'hFFFF.
//   - Cleared by rst_ and by clr.
//  MUL_ARB_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset, req0=1 a0=3 b0=5 for 1 cycle after gnt0:
//     gnt0 1 cycle after req; rsp_valid LAT cycles after gnt0 with rsp_id=0, rsp_data=15; busy 1 then 0.
//  2 req0 and req1 both held high from reset for 8 cycles:
//     grants go gnt0,gnt1,gnt0,... one per cycle; responses come back in grant order with matching ids and products.
//  3 a1=8'hFF b1=8'hFF single issue: rsp_data=16'hFE01, rsp_id=1.
//  4 Issue 3 ops, then assert clr 2 cycles later:
//     no rsp_valid for any of them; busy=0 the cycle after clr; the next req0 is granted normally.
//  5 req0 held high alone for 6 cycles: gnt0 pulses every other cycle (3 grants); none in consecutive cycles.
//  6 With MUL_ARB_STATS_EN, cnt0 preloaded near 16'hFFFE via 3 grants: cnt0 saturates at 16'hFFFF;
//     without the macro, the same bench (no cnt ports) passes scenarios 1-5.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Two-requester round-robin front end for one shared pipelined W x W multiplier.
// Optional per-requester grant counters are enabled by defining MUL_ARB_STATS_EN.
module mul_share_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 4
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic           clr,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    output logic           gnt0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt1,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_data,
    output logic           busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]    cnt0,
    output logic [15:0]    cnt1
`endif
);

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    tag_t [LAT-1:0] tag_q, tag_d;
    logic           rr_q, rr_d;
    logic           elig0, elig1;
    logic           issue, win_id;
    logic           done, any_valid;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        tag_d  = '0;
        issue  = 1'b0;
        win_id = 1'b0;
        rr_d   = rr_q;
        // A requester that was granted last cycle sits out one cycle.
        elig0  = req0 & ~gnt0;
        elig1  = req1 & ~gnt1;

        if (clr) begin
            rr_d = 1'b1;
        end else if (elig0 && elig1) begin
            issue  = 1'b1;
            win_id = ~rr_q;
            rr_d   = ~rr_q;
        end else if (elig0) begin
            issue  = 1'b1;
            win_id = 1'b0;
        end else if (elig1) begin
            issue  = 1'b1;
            win_id = 1'b1;
        end

        tag_d[0] = '{valid: issue, id: win_id};
        for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
        if (clr) begin
            for (int i = 0; i < LAT; i++) tag_d[i].valid = 1'b0;
        end

        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | tag_d[i].valid;

        // The last tag stage lines up with the product currently on mul_p.
        done = tag_q[LAT-1].valid & ~clr;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            // NOTE: the tag pipe is reset because stale valid bits would emit phantom responses.
            tag_q     <= '0;
            rr_q      <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            gnt0      <= issue & ~win_id;
            gnt1      <= issue & win_id;
            if (issue) begin
                mul_a <= win_id ? a1 : a0;
                mul_b <= win_id ? b1 : b0;
            end
            tag_q     <= tag_d;
            rr_q      <= rr_d;
            busy      <= any_valid;
            rsp_valid <= done;
            if (done) begin
                rsp_data <= mul_p;
                rsp_id   <= tag_q[LAT-1].id;
            end
        end
    end

`ifdef MUL_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (gnt1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural LAT-stage multiplier on mul_a/mul_b/mul_p.
module tb_mul_share_arbiter;

    localparam int W   = 8;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           rst_;
    logic           clr;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           rsp_valid, rsp_id;
    logic [2*W-1:0] rsp_data;
    logic           busy;
`ifdef MUL_ARB_STATS_EN
    logic [15:0]    cnt0, cnt1;
`endif

    int tests = 0;
    int fails = 0;
    int grants;
    logic [15:0] exp2 [8] = '{16'd6, 16'd20, 16'd9, 16'd25, 16'd12, 16'd30, 16'd15, 16'd35};

    always #5 clk = ~clk;

    mul_share_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .clr       (clr),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef MUL_ARB_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    // Multiplier model: the operand register inside the DUT is its first stage.
    logic [2*W-1:0] pp [LAT-1];
    initial for (int i = 0; i < LAT-1; i++) pp[i] = '0;
    always @(posedge clk) begin
        pp[0] <= {8'b0, mul_a} * {8'b0, mul_b};
        for (int i = 1; i < LAT-1; i++) pp[i] <= pp[i-1];
    end
    assign mul_p = pp[LAT-2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
        rst_ = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        rst_ = 1'b0; clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("init_gnt0", gnt0, 0);
        check("init_gnt1", gnt1, 0);
        check("init_mul_a", mul_a, 0);
        check("init_mul_b", mul_b, 0);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_rsp_id", rsp_id, 0);
        check("init_rsp_data", rsp_data, 0);
        check("init_busy", busy, 0);
        rst_ = 1'b1;

        // Scenario 1: single req0 op, 3*5
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
        step();
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        check("t1_mul_a", mul_a, 3);
        check("t1_mul_b", mul_b, 5);
        check("t1_busy_on", busy, 1);
        req0 = 1'b0;
        step();
        check("t1_gnt0_off", gnt0, 0);
        step();
        step();
        check("t1_rsp_early", rsp_valid, 0);
        check("t1_busy_mid", busy, 1);
        step();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_data", rsp_data, 15);
        check("t1_busy_off", busy, 0);
        step();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_rsp_hold", rsp_data, 15);

        // Scenario 2: continuous dual request, alternating grants
        do_reset();
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
        req1 = 1'b1; a1 = 8'd4; b1 = 8'd5;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i <= 8) begin
                check("t2_gnt0", gnt0, i % 2);
                check("t2_gnt1", gnt1, 1 - (i % 2));
                if (i % 2 == 1) a0 = a0 + 8'd1;
                else            a1 = a1 + 8'd1;
            end
            if (i == 8) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (i >= 5) begin
                check("t2_rsp_valid", rsp_valid, 1);
                check("t2_rsp_id", rsp_id, (i - 5) % 2);
                check("t2_rsp_data", rsp_data, exp2[i-5]);
            end
        end

        // Scenario 3: full-scale operands on requester 1
        do_reset();
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        step();
        check("t3_gnt1", gnt1, 1);
        req1 = 1'b0;
        step(); step(); step(); step();
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_id", rsp_id, 1);
        check("t3_rsp_data", rsp_data, 16'hFE01);

        // Scenario 4: three ops in flight, flushed by clr which also beats a new req0
        do_reset();
        req0 = 1'b1; a0 = 8'd9;  b0 = 8'd10;
        req1 = 1'b1; a1 = 8'd13; b1 = 8'd2;
        step();
        check("t4_gnt0_a", gnt0, 1);
        a0 = 8'd11; b0 = 8'd12;
        step();
        check("t4_gnt1", gnt1, 1);
        req1 = 1'b0;
        step();
        check("t4_gnt0_b", gnt0, 1);
        check("t4_mul_a_b", mul_a, 11);
        req0 = 1'b0;
        step();
        check("t4_busy_pre", busy, 1);
        clr = 1'b1; req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
        step();
        check("t4_clr_gnt0", gnt0, 0);
        check("t4_clr_rsp", rsp_valid, 0);
        check("t4_clr_busy", busy, 0);
        check("t4_clr_mul_a", mul_a, 11);
        check("t4_clr_mul_b", mul_b, 12);
        clr = 1'b0;
        step();
        check("t4_regrant", gnt0, 1);
        check("t4_no_rsp_a", rsp_valid, 0);
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_no_rsp_b", rsp_valid, 0);
        end
        step();
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_id", rsp_id, 0);
        check("t4_rsp_data", rsp_data, 42);

        // Scenario 5: req0 alone never gets back-to-back grants
        do_reset();
        req0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
        grants = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t5_gnt0", gnt0, i % 2);
            check("t5_gnt1", gnt1, 0);
            if (gnt0) grants++;
        end
        req0 = 1'b0;
        check("t5_grants", grants, 3);

`ifdef MUL_ARB_STATS_EN
        // Scenario 6: grant counter saturates
        do_reset();
        check("t6_cnt0_rst", cnt0, 0);
        force dut.cnt0_q = 16'hFFFD;
        #1;
        release dut.cnt0_q;
        req0 = 1'b1;
        step();
        step();
        check("t6_cnt0_fffe", cnt0, 16'hFFFE);
        step(); step(); step(); step();
        req0 = 1'b0;
        step();
        check("t6_cnt0_sat", cnt0, 16'hFFFF);
        check("t6_cnt1", cnt1, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_cnt0_clr", cnt0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
